// File: rtl/mem_arbiter.sv
// Two-master shared-memory arbiter: data port normally wins over instruction fetch.
// Define MEM_ARB_AGE_EN to let a fetch win after STARVE_LIM consecutive data grants.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_adr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

  state_t state, state_nxt;
  logic   grant_d, grant_i, age_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // No grant in a done cycle, so every access is followed by one idle cycle.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      IDLE: begin
        if (!i_done && !d_done) begin
          if (age_win) begin
            grant_i   = 1'b1;
            state_nxt = INST;
          end else if (d_rd || d_wr) begin
            grant_d   = 1'b1;
            state_nxt = DATA;
          end else if (i_req) begin
            grant_i   = 1'b1;
            state_nxt = INST;
          end
        end
      end
      DATA, INST: begin
        if (m_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_adr   <= '0;
      m_wdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grant_d) begin
        m_req   <= 1'b1;
        m_we    <= d_wr;
        m_adr   <= d_adr;
        m_wdata <= d_wdata;
      end
      if (grant_i) begin
        m_req <= 1'b1;
        m_we  <= 1'b0;
        m_adr <= i_adr;
      end
      if (state == DATA && m_ack) begin
        m_req   <= 1'b0;
        d_rdata <= m_rdata;
        d_done  <= 1'b1;
      end
      if (state == INST && m_ack) begin
        m_req   <= 1'b0;
        i_rdata <= m_rdata;
        i_done  <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_AGE_EN
  localparam int AGE_W = $clog2(STARVE_LIM + 1);

  logic [AGE_W-1:0] age_cnt;

  // Counts data grants that overtook a waiting fetch; saturates because the fetch then wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  age_cnt <= '0;
    else if (!i_req || grant_i) age_cnt <= '0;
    else if (grant_d)          age_cnt <= age_cnt + 1'b1;
  end

  assign age_win = i_req && (age_cnt >= AGE_W'(STARVE_LIM));
`else
  assign age_win = 1'b0;
`endif

  assign stall = ((d_rd | d_wr) & ~d_done) | (i_req & ~i_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model of the arbitration rules.
// Honours MEM_ARB_AGE_EN the same way the design does.
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_LIM = 4;
`ifdef MEM_ARB_AGE_EN
  localparam bit AGE_ON = 1'b1;
`else
  localparam bit AGE_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_adr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              d_rd, d_wr;
  logic [ADDR_W-1:0] d_adr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              m_req, m_we;
  logic [ADDR_W-1:0] m_adr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;
  logic              stall;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_adr(i_adr), .i_rdata(i_rdata), .i_done(i_done),
    .d_rd(d_rd), .d_wr(d_wr), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: what the arbiter must show in the coming cycle. busy: 0 none, 1 data, 2 fetch.
  int                busy;
  int                age;
  logic              exp_req, exp_we, exp_i_done, exp_d_done;
  logic [ADDR_W-1:0] exp_adr;
  logic [DATA_W-1:0] exp_wdata, exp_i_rdata, exp_d_rdata;
  int                mdl_fetch_cnt, obs_fetch_cnt;

  // Requester and memory stimulus knobs
  bit                rand_en, spur_en, d_hold, i_hold, d_drop_next, i_drop_next;
  bit                inj_d, inj_i, inj_rd, inj_wr;
  logic [ADDR_W-1:0] inj_d_adr, inj_i_adr;
  logic [DATA_W-1:0] inj_wdata;
  bit                mem_active, mem_fixed, force_data_en;
  int                mem_cnt;
  logic [DATA_W-1:0] force_data;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("[TB] FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, want);
  endtask

  task automatic clearModel();
    busy = 0; age = 0;
    exp_req = 0; exp_we = 0; exp_i_done = 0; exp_d_done = 0;
    exp_adr = '0; exp_wdata = '0; exp_i_rdata = '0; exp_d_rdata = '0;
    d_drop_next = 0; i_drop_next = 0; mem_active = 0;
  endtask

  task automatic applyStimulus();
    int kind;
    if (d_drop_next) begin d_rd = 0; d_wr = 0; d_drop_next = 0; end
    if (i_drop_next) begin i_req = 0; i_drop_next = 0; end
    if (exp_d_done && !d_hold) d_drop_next = 1;
    if (exp_i_done && !i_hold) i_drop_next = 1;
    if (rand_en) begin
      if ((d_rd | d_wr) && busy == 1 && !exp_d_done && $urandom_range(0, 9) == 0) begin
        d_rd = 0; d_wr = 0;
      end
      if (i_req && busy == 2 && !exp_i_done && $urandom_range(0, 9) == 0) i_req = 0;
      if (!(d_rd | d_wr) && busy != 1 && !exp_d_done && !d_drop_next && $urandom_range(0, 2) == 0) begin
        kind    = $urandom_range(0, 3);
        d_rd    = (kind <= 1) || (kind == 3);
        d_wr    = (kind >= 2);
        d_adr   = ADDR_W'($urandom);
        d_wdata = DATA_W'($urandom);
      end
      if (!i_req && busy != 2 && !exp_i_done && !i_drop_next && $urandom_range(0, 2) == 0) begin
        i_req = 1;
        i_adr = ADDR_W'($urandom);
      end
    end
    if (inj_d) begin
      d_rd = inj_rd; d_wr = inj_wr; d_adr = inj_d_adr; d_wdata = inj_wdata; inj_d = 0;
    end
    if (inj_i) begin
      i_req = 1; i_adr = inj_i_adr; inj_i = 0;
    end
  endtask

  // Memory acks a fixed or random 1..3 cycles after it first sees m_req; returns fresh data per cycle.
  task automatic driveMemory();
    m_ack   = 1'b0;
    m_rdata = DATA_W'($urandom);
    if (m_req) begin
      if (!mem_active) begin
        mem_active = 1;
        mem_cnt    = mem_fixed ? 1 : $urandom_range(1, 3);
      end else begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          m_ack      = 1'b1;
          mem_active = 0;
          if (force_data_en) begin m_rdata = force_data; force_data_en = 0; end
        end
      end
    end else begin
      mem_active = 0;
      if (spur_en && busy == 0 && $urandom_range(0, 5) == 0) m_ack = 1'b1;
    end
  endtask

  // Predicts the effect of the coming clock edge from the current inputs.
  task automatic modelNext();
    bit done_now, gi, gd, starve, dreq;
    done_now   = exp_i_done | exp_d_done;
    gi = 0; gd = 0;
    exp_i_done = 0;
    exp_d_done = 0;
    dreq       = d_rd | d_wr;
    if (busy != 0) begin
      if (m_ack) begin
        exp_req = 0;
        if (busy == 1) begin exp_d_done = 1; exp_d_rdata = m_rdata; end
        else begin exp_i_done = 1; exp_i_rdata = m_rdata; mdl_fetch_cnt++; end
        busy = 0;
      end
    end else if (!done_now) begin
      starve = AGE_ON && i_req && (age >= STARVE_LIM);
      if (starve || (!dreq && i_req)) gi = 1;
      else if (dreq) gd = 1;
    end
    if (gd) begin
      busy = 1; exp_req = 1; exp_we = d_wr; exp_adr = d_adr; exp_wdata = d_wdata;
    end
    if (gi) begin
      busy = 2; exp_req = 1; exp_we = 0; exp_adr = i_adr;
    end
    if (!AGE_ON || !i_req || gi) age = 0;
    else if (gd) age++;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    checkOutput("m_req",   m_req,   exp_req);
    checkOutput("m_we",    m_we,    exp_we);
    checkOutput("m_adr",   m_adr,   exp_adr);
    checkOutput("m_wdata", m_wdata, exp_wdata);
    checkOutput("i_done",  i_done,  exp_i_done);
    checkOutput("d_done",  d_done,  exp_d_done);
    checkOutput("i_rdata", i_rdata, exp_i_rdata);
    checkOutput("d_rdata", d_rdata, exp_d_rdata);
    if (i_done) obs_fetch_cnt++;
    applyStimulus();
    #1;
    checkOutput("stall", stall, ((d_rd | d_wr) & ~exp_d_done) | (i_req & ~exp_i_done));
    driveMemory();
    modelNext();
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_m_req"},   m_req,   1'b0);
    checkOutput({tag, "_m_we"},    m_we,    1'b0);
    checkOutput({tag, "_i_done"},  i_done,  1'b0);
    checkOutput({tag, "_d_done"},  d_done,  1'b0);
    checkOutput({tag, "_m_adr"},   m_adr,   '0);
    checkOutput({tag, "_m_wdata"}, m_wdata, '0);
    checkOutput({tag, "_i_rdata"}, i_rdata, '0);
    checkOutput({tag, "_d_rdata"}, d_rdata, '0);
  endtask

  initial begin
    rst = 0; i_req = 0; i_adr = '0; d_rd = 0; d_wr = 0; d_adr = '0; d_wdata = '0;
    m_ack = 0; m_rdata = '0;
    rand_en = 0; spur_en = 0; d_hold = 0; i_hold = 0; inj_d = 0; inj_i = 0;
    inj_rd = 0; inj_wr = 0; inj_d_adr = '0; inj_i_adr = '0; inj_wdata = '0;
    mem_fixed = 0; force_data_en = 0; force_data = '0; mem_cnt = 0;
    mdl_fetch_cnt = 0; obs_fetch_cnt = 0;
    clearModel();

    // Fetch of 0x40 pending during reset; the first grant must wait for reset release.
    #2;
    checkResetState("rst");
    i_req = 1; i_adr = 32'h40;
    mem_fixed = 1; force_data_en = 1; force_data = 32'h8C010004;
    @(posedge clk); #1;
    checkOutput("rst_hold_m_req", m_req, 1'b0);
    checkOutput("rst_hold_stall", stall, 1'b1);
    @(negedge clk);
    rst = 1;
    modelNext();
    runCycles(6);
    checkOutput("fetch40_rdata", i_rdata, 32'h8C010004);

    // Store and fetch arrive together: store first, then the fetch.
    inj_d = 1; inj_rd = 0; inj_wr = 1; inj_d_adr = 32'h100; inj_wdata = 32'hDEADBEEF;
    inj_i = 1; inj_i_adr = 32'h200;
    runCycles(14);

    // Load and store together behave as a single store.
    inj_d = 1; inj_rd = 1; inj_wr = 1; inj_d_adr = 32'h20; inj_wdata = 32'h12345678;
    runCycles(8);

    // Random traffic with random memory latency, spurious acks and early request drops.
    mem_fixed = 0; rand_en = 1; spur_en = 1;
    runCycles(400);

    // Reset in the middle of an access.
    begin
      int n;
      n = 0;
      while (n < 50 && !(busy != 0 && exp_req)) begin
        stepCycle();
        n++;
      end
      checkOutput("rst_wait_busy", (busy != 0 && exp_req), 1'b1);
    end
    rand_en = 0; spur_en = 0;
    #1;
    rst = 0;
    #1;
    checkResetState("mid_rst");
    clearModel();
    i_req = 0; d_rd = 0; d_wr = 1; d_adr = 32'h300; d_wdata = 32'hCAFE0001; m_ack = 0;
    @(posedge clk); #1;
    checkOutput("mid_rst_hold_m_req", m_req, 1'b0);
    checkOutput("mid_rst_no_done", {31'b0, d_done | i_done}, 32'h0);
    @(negedge clk);
    rst = 1;
    modelNext();
    runCycles(10);

    // Load held continuously with a waiting fetch: starvation rule decides fetch grants.
    spur_en = 0;
    runCycles(6);
    mdl_fetch_cnt = 0; obs_fetch_cnt = 0;
    d_hold = 1; i_hold = 1;
    inj_d = 1; inj_rd = 1; inj_wr = 0; inj_d_adr = 32'h80; inj_wdata = '0;
    inj_i = 1; inj_i_adr = 32'h44;
    runCycles(60);
    checkOutput("age_fetches", obs_fetch_cnt, mdl_fetch_cnt);
    checkOutput("age_fetches_expected", (mdl_fetch_cnt > 0), AGE_ON);
    d_hold = 0; i_hold = 0;
    runCycles(30);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_LIM, default 4, the number of consecutive data grants tolerated before a waiting fetch wins (used only with MEM_ARB_AGE_EN).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_req, input, 1, instruction-fetch request, held until i_done.
REQ-007 SHALL have port i_adr, input, ADDR_W, fetch address.
REQ-008 SHALL have port i_rdata, output, DATA_W, fetched instruction, valid while i_done=1.
REQ-009 SHALL have port i_done, output, 1, one-cycle fetch completion pulse.
REQ-010 SHALL have port d_rd, input, 1, data load request.
REQ-011 SHALL have port d_wr, input, 1, data store request.
REQ-012 SHALL have port d_adr, input, ADDR_W, load/store address.
REQ-013 SHALL have port d_wdata, input, DATA_W, store data.
REQ-014 SHALL have port d_rdata, output, DATA_W, load data, valid while d_done=1.
REQ-015 SHALL have port d_done, output, 1, one-cycle load/store completion pulse.
REQ-016 SHALL have ports m_req (output, 1), m_we (output, 1), m_adr (output, ADDR_W), m_wdata (output, DATA_W), the shared-memory request.
REQ-017 SHALL have ports m_rdata (input, DATA_W) and m_ack (input, 1), the shared-memory response; m_ack is high for one cycle per access.
REQ-018 SHALL have port stall, output, 1, pipeline freeze request to PC, IF/ID and later stage registers.

Function
REQ-019 SHALL implement FSM states IDLE, DATA, INST.
REQ-020 In IDLE with a data request (d_rd|d_wr), SHALL latch d_adr, d_wdata, and m_we=d_wr into registers and enter DATA; otherwise, with i_req, SHALL latch i_adr, m_we=0 and enter INST.
REQ-021 Data SHALL have priority over fetch when both are pending in IDLE (strict priority without MEM_ARB_AGE_EN).
REQ-022 m_req SHALL be registered: high from the cycle after the grant edge until the cycle containing m_ack, inclusive; m_adr/m_wdata/m_we SHALL remain stable throughout.
REQ-023 On m_ack in DATA/INST, SHALL capture m_rdata into d_rdata/i_rdata, pulse d_done/i_done in the next cycle, and return to IDLE; minimum request-to-done latency is 3 cycles with 1-cycle memory.
REQ-024 d_rd and d_wr both high SHALL be treated as a store; the load is dropped.
REQ-025 m_ack while in IDLE SHALL be ignored.
REQ-026 A request deasserted mid-transaction SHALL NOT abort the access; the done pulse is still issued.
REQ-027 A new grant SHALL NOT occur in the cycle a done pulse is asserted (one idle cycle between accesses).
REQ-028 stall SHALL be combinational: (d_rd|d_wr) & ~d_done | i_req & ~i_done.
REQ-029 i_rdata/d_rdata SHALL hold their last captured values between accesses.

Reset
REQ-030 On rst=0, SHALL asynchronously enter IDLE and clear m_req, m_we, i_done, d_done, m_adr, m_wdata, i_rdata, d_rdata, and the age counter to 0.
REQ-031 Reset mid-access SHALL drop m_req immediately; no done pulse SHALL follow for the aborted access.
REQ-032 The first grant after reset release SHALL occur no earlier than the first rising edge with rst=1.

Configuration
REQ-033 With MEM_ARB_AGE_EN defined, SHALL count consecutive data grants made while i_req=1, and when the count reaches STARVE_LIM SHALL grant the fetch at the next IDLE decision and clear the count; the count SHALL also clear on any fetch grant or when i_req=0.
REQ-034 Without MEM_ARB_AGE_EN, SHALL contain no age counter and SHALL apply strict data priority.

Verification
REQ-035 Fetch only, i_adr=0x40, memory acks 1 cycle after m_req with 0x8C010004 -> m_adr=0x40, m_we=0, i_done pulse with i_rdata=0x8C010004, stall high until that cycle.
REQ-036 Simultaneous i_req and d_wr (adr 0x100, data 0xDEADBEEF) -> store granted first with m_we=1; fetch granted after d_done; i_done follows.
REQ-037 d_rd and d_wr both high, adr 0x20 -> a single access with m_we=1; d_done after m_ack; no read access issued.
REQ-038 rst pulled low while m_req=1 and m_ack is pending -> m_req=0 in the same cycle, no i_done/d_done, FSM in IDLE.
REQ-039 MEM_ARB_AGE_EN defined, STARVE_LIM=4, d_rd held continuously with i_req=1 -> 4 data accesses, then 1 fetch, then data resumes; undefined -> fetch never granted while d_rd stays high.
REQ-040 m_ack asserted spuriously in IDLE -> no done pulse, no state change.
